// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the partial-sum accumulator array.
// Saturation limits are functions of the psum width so any lane width up to 63 bits works.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int WIDE_BW = 64;

    function automatic logic signed [WIDE_BW-1:0] sat_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [WIDE_BW-1:0] sat_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

    // Operands are sign-extended bw-bit values, so the 64-bit sum itself never overflows.
    function automatic logic signed [WIDE_BW-1:0] sat_add(
        input logic signed [WIDE_BW-1:0] a,
        input logic signed [WIDE_BW-1:0] b,
        input int                        bw
    );
        logic signed [WIDE_BW-1:0] s;
        s = a + b;
        if (s > sat_max(bw)) return sat_max(bw);
        if (s < sat_min(bw)) return sat_min(bw);
        return s;
    endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// One column lane: acc_depth entries with read-modify-write accumulate, clear-on-read and ReLU/threshold.
// Define PSUM_ACC_SAT_EN to make the accumulate add saturate instead of wrap.
module psum_acc_lane
    import psum_acc_pkg::*;
#(
    parameter int psum_bw   = 16,
    parameter int acc_depth = 16,
    parameter int addr_bw   = $clog2(acc_depth)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic                      acc,
    input  logic [addr_bw-1:0]        wr_addr,
    input  logic signed [psum_bw-1:0] wr_data,
    input  logic                      clr_en,
    input  logic [addr_bw-1:0]        rd_addr,
    input  logic                      relu,
    input  logic signed [psum_bw-1:0] thres,
    output logic signed [psum_bw-1:0] rd_data
);

    logic signed [psum_bw-1:0] mem [acc_depth];
    logic signed [psum_bw-1:0] cur;
    logic signed [psum_bw-1:0] sum;
    logic signed [psum_bw-1:0] raw;

    assign cur = mem[wr_addr];

`ifdef PSUM_ACC_SAT_EN
    always_comb begin
        sum = psum_bw'(sat_add(WIDE_BW'(cur), WIDE_BW'(wr_data), psum_bw));
    end
`else
    always_comb begin
        sum = cur + wr_data;
    end
`endif

    // Writes only happen in IDLE and clears only in DRAIN, so the two never target the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < acc_depth; i++) mem[i] <= '0;
        end else begin
            if (wr_en) mem[wr_addr] <= acc ? sum : wr_data;
            if (clr_en) mem[rd_addr] <= '0;
        end
    end

    always_comb begin
        raw     = mem[rd_addr];
        rd_data = (relu && (raw < thres)) ? '0 : raw;
    end

endmodule

// File: rtl/psum_acc_array.sv
// Multi-lane partial-sum accumulator: accumulate by address, then drain in address order through ReLU/threshold.
// Build option: PSUM_ACC_SAT_EN selects saturating accumulation in every lane.
module psum_acc_array
    import psum_acc_pkg::*;
#(
    parameter int col       = 8,
    parameter int psum_bw   = 16,
    parameter int acc_depth = 16,
    parameter int addr_bw   = $clog2(acc_depth)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [psum_bw*col-1:0] in,
    input  logic [addr_bw-1:0]     in_addr,
    input  logic                   acc,
    input  logic                   drain,
    input  logic                   relu,
    input  logic [psum_bw-1:0]     thres,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [psum_bw*col-1:0] out,
    output logic [addr_bw-1:0]     out_addr,
    output logic                   busy
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // out/out_addr hold while out_valid & !out_ready, and out_valid never drops without a transfer.

    state_t                 state, state_nxt;
    logic [addr_bw-1:0]     ptr;
    logic                   relu_q;
    logic [psum_bw-1:0]     thres_q;
    logic                   wr_fire;
    logic                   load;
    logic [psum_bw*col-1:0] lane_out;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign wr_fire  = in_valid & in_ready;
    assign load     = (state == DRAIN) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (drain) state_nxt = DRAIN;
            DRAIN:   if (load && (ptr == addr_bw'(acc_depth - 1))) state_nxt = FLUSH;
            FLUSH:   if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr     <= '0;
            relu_q  <= 1'b0;
            thres_q <= '0;
        end else if (state == IDLE && drain) begin
            ptr     <= '0;
            relu_q  <= relu;
            thres_q <= thres;
        end else if (load) begin
            ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_addr  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out       <= lane_out;
            out_addr  <= ptr;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < col; g++) begin : g_lane
        psum_acc_lane #(
            .psum_bw  (psum_bw),
            .acc_depth(acc_depth),
            .addr_bw  (addr_bw)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (wr_fire),
            .acc    (acc),
            .wr_addr(in_addr),
            .wr_data(in[psum_bw*g +: psum_bw]),
            .clr_en (load),
            .rd_addr(ptr),
            .relu   (relu_q),
            .thres  (thres_q),
            .rd_data(lane_out[psum_bw*g +: psum_bw])
        );
    end

endmodule

// File: tb/tb_psum_acc_array.sv
// Directed bench for psum_acc_array: reset, accumulate/overwrite, threshold, backpressure, overflow, abort.
// Expected overflow result follows PSUM_ACC_SAT_EN when the bench is built with it.
module tb_psum_acc_array;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int VW  = COL * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_vec = '0;
    logic [AW-1:0] in_addr = '0;
    logic          acc = 1'b0;
    logic          drain = 1'b0;
    logic          relu = 1'b0;
    logic [BW-1:0] thres = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] out_vec;
    logic [AW-1:0] out_addr;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [VW-1:0] got [DEP];

    psum_acc_array #(.col(COL), .psum_bw(BW), .acc_depth(DEP), .addr_bw(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (in_vec),
        .in_addr  (in_addr),
        .acc      (acc),
        .drain    (drain),
        .relu     (relu),
        .thres    (thres),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out_vec),
        .out_addr (out_addr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack4(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                            input logic [BW-1:0] c, input logic [BW-1:0] d);
        logic [VW-1:0] v;
        v = '0;
        v[0*BW +: BW] = a;
        v[1*BW +: BW] = b;
        v[2*BW +: BW] = c;
        v[3*BW +: BW] = d;
        return v;
    endfunction

    // Leaves in_valid high so consecutive calls produce back-to-back writes.
    task automatic wr(input logic [AW-1:0] a, input logic [VW-1:0] v, input logic accum);
        in_valid = 1'b1;
        in_addr  = a;
        in_vec   = v;
        acc      = accum;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        acc      = 1'b0;
        in_vec   = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  VW'(in_ready),  VW'(1'b1));
        chk({tag, "_out_valid"}, VW'(out_valid), VW'(1'b0));
        chk({tag, "_out"},       out_vec,        '0);
        chk({tag, "_out_addr"},  VW'(out_addr),  '0);
        chk({tag, "_busy"},      VW'(busy),      VW'(1'b0));
    endtask

    // bp=0: out_ready always high (also checks cycle timing); bp=1: out_ready pattern 1,0,0,1,0,0...
    task automatic do_drain(input string tag, input logic r, input logic [BW-1:0] th, input int bp);
        int n, cyc, first;
        logic [VW-1:0] held;
        logic [AW-1:0] held_a;
        logic stalled;
        drain = 1'b1;
        relu  = r;
        thres = th;
        step();
        drain = 1'b0;
        relu  = 1'b0;
        thres = '0;
        idle();
        chk({tag, "_busy_t1"},     VW'(busy),     VW'(1'b1));
        chk({tag, "_in_ready_t1"}, VW'(in_ready), VW'(1'b0));
        n = 0; cyc = 0; first = -1; stalled = 1'b0; held = '0; held_a = '0;
        while (n < DEP && cyc < 200) begin
            out_ready = (bp == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (stalled) begin
                chk({tag, "_stall_valid"}, VW'(out_valid), VW'(1'b1));
                chk({tag, "_stall_out"},   out_vec,        held);
                chk({tag, "_stall_addr"},  VW'(out_addr),  VW'(held_a));
            end
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (out_ready) begin
                    chk({tag, "_addr_order"}, VW'(out_addr), VW'(n));
                    got[n] = out_vec;
                    n++;
                    stalled = 1'b0;
                end else begin
                    held    = out_vec;
                    held_a  = out_addr;
                    stalled = 1'b1;
                end
            end
            step();
            cyc++;
        end
        out_ready = 1'b1;
        chk({tag, "_count"}, VW'(n), VW'(DEP));
        if (bp == 0) begin
            chk({tag, "_first_valid_cyc"}, VW'(first), VW'(1));
            chk({tag, "_last_hs_cyc"},     VW'(cyc),   VW'(DEP + 1));
            chk({tag, "_idle_after"},      VW'(in_ready), VW'(1'b1));
        end
        for (int k = 0; k < 50 && busy; k++) step();
        chk({tag, "_not_busy"}, VW'(busy), VW'(1'b0));
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < DEP; i++) chk($sformatf("%s_zero%0d", tag, i), got[i], '0);
    endtask

    initial begin
        logic [VW-1:0] ovf_exp;
        int k;

        // Reset state
        reset = 1'b0;
        step(); step(); step();
        chk_reset_outputs("rst");
        reset = 1'b1;
        step();
        chk_reset_outputs("rst_rel");
        do_drain("d_rst", 1'b0, '0, 0);
        chk_all_zero("d_rst");

        // Accumulate and overwrite: 5, +7, -2 back to back -> 10
        wr(4'd3, pack4(16'd5, 0, 0, 0), 1'b0);
        wr(4'd3, pack4(16'd7, 0, 0, 0), 1'b1);
        wr(4'd3, pack4(16'hFFFE, 0, 0, 0), 1'b1);
        idle();
        step();
        do_drain("d_acc", 1'b0, '0, 0);
        for (int i = 0; i < DEP; i++)
            chk($sformatf("acc_addr%0d", i), got[i], (i == 3) ? pack4(16'd10, 0, 0, 0) : '0);

        // Threshold: -4,3,0,9 with thres=1 -> 0,3,0,9
        wr(4'd0, pack4(16'hFFFC, 16'd3, 16'd0, 16'd9), 1'b0);
        idle();
        do_drain("d_thr", 1'b1, 16'd1, 0);
        chk("thr_addr0", got[0], pack4(16'd0, 16'd3, 16'd0, 16'd9));
        do_drain("d_thr2", 1'b0, '0, 0);
        chk_all_zero("d_thr2");

        // Backpressure with distinct data at every address
        for (int i = 0; i < DEP; i++) wr(AW'(i), pack4(16'(i * 3 + 1), 16'(100 + i), 0, 16'(i)), 1'b0);
        idle();
        do_drain("d_bp", 1'b0, '0, 1);
        for (int i = 0; i < DEP; i++)
            chk($sformatf("bp_addr%0d", i), got[i], pack4(16'(i * 3 + 1), 16'(100 + i), 0, 16'(i)));

        // Overflow on lane 0 at addr 1, plus a negative-side lane 1 wrap/saturate
        wr(4'd1, pack4(16'd32767, 16'h8000, 0, 0), 1'b0);
        wr(4'd1, pack4(16'd1, 16'hFFFF, 0, 0), 1'b1);
        idle();
        do_drain("d_ovf", 1'b0, '0, 0);
`ifdef PSUM_ACC_SAT_EN
        ovf_exp = pack4(16'h7FFF, 16'h8000, 0, 0);
`else
        ovf_exp = pack4(16'h8000, 16'h7FFF, 0, 0);
`endif
        chk("ovf_addr1", got[1], ovf_exp);

        // Write in the same cycle as drain is included
        wr(4'd10, pack4(16'd9, 0, 0, 0), 1'b0);
        in_valid = 1'b1;
        in_addr  = 4'd2;
        in_vec   = pack4(16'd4, 0, 0, 0);
        acc      = 1'b0;
        do_drain("d_sim", 1'b0, '0, 0);
        chk("sim_addr2", got[2], pack4(16'd4, 0, 0, 0));
        chk("sim_addr10", got[10], pack4(16'd9, 0, 0, 0));
        chk("sim_addr3", got[3], '0);

        // Reset mid-drain at addr 6 aborts and zeroes undrained entries
        wr(4'd12, pack4(16'd3, 16'd3, 0, 0), 1'b0);
        wr(4'd4, pack4(16'd8, 0, 0, 0), 1'b0);
        idle();
        drain = 1'b1;
        step();
        drain = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (!(out_valid && out_addr == 4'd6) && k < 100) begin
            step();
            k++;
        end
        chk("abort_reached6", VW'(out_valid && out_addr == 4'd6), VW'(1'b1));
        reset = 1'b0;
        step();
        chk_reset_outputs("abort_rst");
        step();
        reset = 1'b1;
        step();
        chk_reset_outputs("abort_rel");
        do_drain("d_abort", 1'b0, '0, 0);
        chk_all_zero("d_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
